// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time to
// instruction memory, holds the returned word for decode and handles
// redirects, including squashing a fetch that is still in flight.
//
// state | meaning
// ------+-----------------------------------------------------------------
// REQ   | request pending on imem_req_*, waiting for memory to accept it
// WAIT  | request accepted, waiting for the response beat
// HOLD  | instruction presented on inst/inst_pc, waiting for decode
// DROP  | redirected while a fetch was in flight; discard its response
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t state, state_next;

  // pc is kept word-aligned at all times, so it can drive the address directly.
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic [31:0]     fetch_count_q;

  logic load_redirect;
  logic fetch_accept;
  logic resp_capture;
  logic inst_xfer;

  // Byte offset of a redirect target is meaningless for word fetches.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, handshake outputs and datapath strobes; redirect wins everywhere.
  always_comb begin
    state_next     = state;
    load_redirect  = 1'b0;
    fetch_accept   = 1'b0;
    resp_capture   = 1'b0;
    inst_xfer      = 1'b0;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;

    unique case (state)
      REQ: begin
        imem_req_valid = !redirect_valid;
        if (redirect_valid) begin
          load_redirect = 1'b1;
        end else if (imem_req_ready) begin
          fetch_accept = 1'b1;
          state_next   = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          load_redirect = 1'b1;
          state_next    = imem_resp_valid ? REQ : DROP;
        end else if (imem_resp_valid) begin
          resp_capture = 1'b1;
          state_next   = HOLD;
        end
      end

      HOLD: begin
        inst_valid = 1'b1;
        if (redirect_valid) begin
          load_redirect = 1'b1;
          state_next    = REQ;
        end else if (inst_ready) begin
          inst_xfer  = 1'b1;
          state_next = REQ;
        end
      end

      DROP: begin
        if (redirect_valid) begin
          load_redirect = 1'b1;
        end
        if (imem_resp_valid) begin
          state_next = REQ;
        end
      end

      default: begin
        state_next = REQ;
      end
    endcase

    // Nothing is offered on either channel while reset is held.
    if (rst) begin
      imem_req_valid = 1'b0;
      inst_valid     = 1'b0;
    end
  end

  // PC, in-flight fetch address, held instruction and delivered count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= {RESET_PC[XLEN-1:2], 2'b00};
      fetch_pc      <= '0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      fetch_count_q <= '0;
    end else begin
      if (load_redirect) begin
        pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (resp_capture) begin
        pc <= fetch_pc + XLEN'(4);
      end

      if (fetch_accept) begin
        fetch_pc <= pc;
      end

      if (resp_capture) begin
        inst_q    <= imem_resp_data;
        inst_pc_q <= fetch_pc;
      end

      if (inst_xfer) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  assign imem_req_addr = pc;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Upstream neighbour of the immediate generator and decoder in the RV32 datapath.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel.
- Holds each returned instruction word, with its PC, on a valid/ready output. The decoder and immediate generator consume that instruction.
- Handles redirects from branches and jumps, including killing an in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, data and address width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch byte address, word-aligned.
- imem_req_ready  in  1  memory accepts the request.
- imem_resp_valid  in  1  response data valid, one cycle.
- imem_resp_data  in  XLEN  fetched instruction word.
- redirect_valid  in  1  change-of-flow from execute.
- redirect_pc  in  XLEN  redirect target.
- inst_valid  out  1  instruction available to decode.
- inst  out  XLEN  instruction word, feeding the decoder and immediate generator.
- inst_pc  out  XLEN  PC of inst.
- inst_ready  in  1  decode accepts inst.
- fetch_count  out  32  number of instructions delivered, wrapping.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high, sampled on the clk rising edge.
- Reset values:
  - pc = RESET_PC, state = REQ.
  - inst = 0, inst_pc = 0, fetch_count = 0.
  - While rst is high, imem_req_valid = 0 and inst_valid = 0.
  - Reset asserted in any state, including WAIT or DROP, abandons the outstanding fetch. A response arriving after reset is ignored only if it lands in REQ; the memory is required to be reset alongside this block.
- Address rules:
  - imem_req_addr = {pc[31:2], 2'b00}. redirect_pc[1:0] is ignored.
  - Next PC = fetch PC + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- At most one outstanding request. imem_resp_valid is only legal at least one cycle after request acceptance; any response seen in REQ or HOLD is ignored.
- FSM states: REQ, WAIT, HOLD, DROP. Redirect has the highest priority in every state.
- REQ:
  - imem_req_valid = !redirect_valid.
  - redirect_valid: pc <= redirect_pc; stay in REQ.
  - Else, on req_valid && req_ready: latch fetch_pc <= pc and go to WAIT.
  - Otherwise hold imem_req_addr stable.
- WAIT:
  - imem_req_valid = 0.
  - resp_valid without redirect: inst <= resp_data, inst_pc <= fetch_pc, pc <= fetch_pc + 4; go to HOLD.
  - redirect with resp_valid in the same cycle: discard data, pc <= redirect_pc; go to REQ.
  - redirect without resp_valid: pc <= redirect_pc; go to DROP.
- DROP:
  - The next resp_valid is discarded; go to REQ.
  - Redirect in DROP updates pc and stays in DROP, or goes to REQ if resp_valid is also high.
- HOLD:
  - inst_valid = 1. inst and inst_pc are stable until the transfer or a flush.
  - Transfer = inst_valid && inst_ready && !redirect_valid. On transfer: fetch_count++ and go to REQ.
  - redirect_valid (with or without inst_ready): no transfer, no count, pc <= redirect_pc; go to REQ. inst_valid = 0 from the next cycle.
- Latency and throughput:
  - Request accepted in cycle N, response in N+1 gives inst_valid in N+2.
  - With ready memory and decode, the next request issues in N+3, so minimum 3 cycles per instruction.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- No X propagation: inst and inst_pc hold their last values when inst_valid = 0.

Test Plan:
- Reset release, memory always ready, 1-cycle response, decode always ready:
  - Required: requests to 0x0, 0x4, 0x8.
  - Required: inst_valid pulses every 3 cycles with inst_pc 0x0, 0x4, 0x8.
  - Required: fetch_count = 3 after the third transfer.
- Decode backpressure: inst_ready = 0 for 5 cycles in HOLD.
  - Required: inst and inst_pc stable.
  - Required: no imem_req_valid.
  - Required: fetch_count unchanged until ready.
- Redirect to 0x100 while in WAIT, response one cycle later with data 0xDEADBEEF.
  - Required: the response is dropped, never shown on inst.
  - Required: the next request address is 0x100.
- Redirect to 0x203 in the same cycle as inst_ready in HOLD.
  - Required: no count increment.
  - Required: inst_valid low the next cycle.
  - Required: next imem_req_addr = 0x200.
- Memory stall: imem_req_ready low for 4 cycles.
  - Required: imem_req_valid held high with a stable address.
  - Required: rst asserted mid-WAIT returns the block to REQ at RESET_PC with fetch_count = 0.
- PC wrap: redirect to 0xFFFF_FFFC, fetch completes.
  - Required: inst_pc = 0xFFFF_FFFC.
  - Required: next imem_req_addr = 0x0000_0000.
